lsu_dm_master: RTL and testbench

//  CPU-side load/store initiator for the data-memory port (dm_addr/dm_we/read_type/write_type/dm_din/dm_dout).

---
 rtl/lsu_dm_master_if.sv | 30 +++
 rtl/lsu_dm_master.sv | 124 ++++++++++++
 tb/tb_lsu_dm_master.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_dm_master_if.sv
// Bundle for the MEM-stage request side and the data-memory port of lsu_dm_master.
// master = the load/store unit, slave = pipeline + data memory.
interface lsu_dm_master_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [31:0]       req_rdata;
  logic              stall;
  logic              misalign_trap;
  logic [ADDR_W-1:0] dm_addr;
  logic              dm_we;
  logic [2:0]        read_type;
  logic [1:0]        write_type;
  logic [31:0]       dm_din;
  logic [31:0]       dm_dout;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, dm_dout,
    output req_rdata, stall, misalign_trap, dm_addr, dm_we, read_type, write_type, dm_din
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, dm_dout,
    input  req_rdata, stall, misalign_trap, dm_addr, dm_we, read_type, write_type, dm_din
  );
endinterface

// File: rtl/lsu_dm_master.sv
// MEM-stage load/store initiator: aligned ops pass through, misaligned h/w are split into bytes.
// Define MISALIGN_TRAP_EN to flag misaligned accesses with misalign_trap instead of splitting.
module lsu_dm_master #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 3
) (
  input logic            clk,
  input logic            rst,
  lsu_dm_master_if.master lsu
);
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;

  state_t           r_state, w_nstate;
  logic [CNT_W-1:0] r_cnt, w_ncnt;
  logic [31:0]      r_buf;

  logic [2:0]       w_f3;
  logic             w_legal, w_half, w_word, w_mis, w_split_go, w_issue;
  logic [CNT_W-1:0] w_last, w_idx;

  assign w_f3    = lsu.req_funct3;
  assign w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                   (((w_f3 == 3'b100) || (w_f3 == 3'b101)) && !lsu.req_we);
  assign w_half  = (w_f3[1:0] == 2'b01);
  assign w_word  = (w_f3 == 3'b010);
  assign w_mis   = lsu.req_valid && w_legal &&
                   ((w_word && (lsu.req_addr[1:0] != 2'b00)) || (w_half && lsu.req_addr[0]));
  assign w_last  = w_word ? CNT_W'(3) : CNT_W'(1);
  assign w_split_go = w_mis && !TRAP;

  // Byte 0 goes out in the same IDLE cycle the misalignment is detected.
  assign w_issue = lsu.req_valid &&
                   (((r_state == IDLE) && w_split_go) || (r_state == SPLIT));
  assign w_idx   = (r_state == SPLIT) ? r_cnt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      if (w_issue && !lsu.req_we)
        r_buf[8*w_idx[1:0] +: 8] <= lsu.dm_dout[7:0];
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    case (r_state)
      IDLE: if (w_split_go) begin
        w_nstate = SPLIT;
        w_ncnt   = CNT_W'(1);
      end
      SPLIT: begin
        if (!lsu.req_valid) begin
          w_nstate = IDLE;
          w_ncnt   = '0;
        end else if (r_cnt == w_last) begin
          w_nstate = DONE;
          w_ncnt   = '0;
        end else begin
          w_ncnt = r_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        w_nstate = IDLE;
        w_ncnt   = '0;
      end
      default: begin
        w_nstate = IDLE;
        w_ncnt   = '0;
      end
    endcase
  end

  // rst gates the strobes so a reset mid-split stops writes without waiting for an edge.
  always_comb begin
    lsu.dm_addr       = lsu.req_addr;
    lsu.dm_we         = 1'b0;
    lsu.read_type     = 3'd0;
    lsu.write_type    = 2'd0;
    lsu.dm_din        = lsu.req_wdata;
    lsu.req_rdata     = 32'd0;
    lsu.stall         = 1'b0;
    lsu.misalign_trap = 1'b0;
    if (!rst && lsu.req_valid) begin
      if (w_issue) begin
        lsu.dm_addr    = lsu.req_addr + ADDR_W'(w_idx);
        lsu.read_type  = 3'd2;
        lsu.write_type = 2'd1;
        lsu.dm_din     = {4{lsu.req_wdata[8*w_idx[1:0] +: 8]}};
        lsu.dm_we      = lsu.req_we;
        lsu.stall      = 1'b1;
      end else if (r_state == DONE) begin
        if (w_word)           lsu.req_rdata = r_buf;
        else if (w_f3[2])     lsu.req_rdata = {16'd0, r_buf[15:0]};
        else                  lsu.req_rdata = {{16{r_buf[15]}}, r_buf[15:0]};
      end else if ((r_state == IDLE) && w_legal) begin
        if (w_mis) begin
          lsu.misalign_trap = TRAP;
        end else begin
          lsu.dm_we     = lsu.req_we;
          lsu.req_rdata = lsu.dm_dout;
          case (w_f3)
            3'b000:  begin lsu.read_type = 3'd1; lsu.write_type = 2'd1; end
            3'b001:  begin lsu.read_type = 3'd3; lsu.write_type = 2'd2; end
            3'b100:  lsu.read_type = 3'd2;
            3'b101:  lsu.read_type = 3'd4;
            default: begin lsu.read_type = 3'd0; lsu.write_type = 2'd0; end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_lsu_dm_master.sv
// Scoreboarded bench for lsu_dm_master: byte-array data memory, reference model, directed + random ops.
module tb_lsu_dm_master;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_dm_master_if #(.ADDR_W(32)) bus();
  lsu_dm_master #(.ADDR_W(32), .CNT_W(3)) dut (.clk(clk), .rst(rst), .lsu(bus));

  logic [7:0] dm_mem  [256];
  logic [7:0] ref_mem [256];
  logic       preload = 1'b0;
  logic       mon_en  = 1'b1;
  logic [7:0] ra;
  assign ra = bus.dm_addr[7:0];

  // Data memory: asynchronous read, byte/half/word write at the clock edge.
  always_comb begin
    case (bus.read_type)
      3'd0:    bus.dm_dout = {dm_mem[ra+8'd3], dm_mem[ra+8'd2], dm_mem[ra+8'd1], dm_mem[ra]};
      3'd1:    bus.dm_dout = {{24{dm_mem[ra][7]}}, dm_mem[ra]};
      3'd2:    bus.dm_dout = {24'd0, dm_mem[ra]};
      3'd3:    bus.dm_dout = {{16{dm_mem[ra+8'd1][7]}}, dm_mem[ra+8'd1], dm_mem[ra]};
      3'd4:    bus.dm_dout = {16'd0, dm_mem[ra+8'd1], dm_mem[ra]};
      default: bus.dm_dout = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) dm_mem[i] <= ref_mem[i];
    end else if (bus.dm_we) begin
      case (bus.write_type)
        2'd0: begin
          dm_mem[ra] <= bus.dm_din[7:0];         dm_mem[ra+8'd1] <= bus.dm_din[15:8];
          dm_mem[ra+8'd2] <= bus.dm_din[23:16];  dm_mem[ra+8'd3] <= bus.dm_din[31:24];
        end
        2'd1: dm_mem[ra] <= bus.dm_din[7:0];
        2'd2: begin dm_mem[ra] <= bus.dm_din[7:0]; dm_mem[ra+8'd1] <= bus.dm_din[15:8]; end
        default: ;
      endcase
    end
  end

  typedef struct {
    logic        chk_rd;
    logic [31:0] rd;
    int          stalls;
    logic        trap;
  } exp_t;
  exp_t sbq[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: little-endian byte memory, size from funct3, misaligned = addr not a multiple of size.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output exp_t e);
    int size;
    logic sgn, mis;
    logic [31:0] v, a;
    e.chk_rd = 1'b1; e.rd = 32'd0; e.stalls = 0; e.trap = 1'b0;
    case (f3)
      3'b000: begin size = 1; sgn = 1'b1; end
      3'b100: begin size = 1; sgn = 1'b0; end
      3'b001: begin size = 2; sgn = 1'b1; end
      3'b101: begin size = 2; sgn = 1'b0; end
      3'b010: begin size = 4; sgn = 1'b0; end
      default: begin size = 0; sgn = 1'b0; end
    endcase
    if (size == 0 || (we && f3[2])) return;
    mis = (addr % size) != 0;
`ifdef MISALIGN_TRAP_EN
    if (mis) begin e.trap = 1'b1; return; end
`else
    e.stalls = mis ? size : 0;
`endif
    if (we) begin
      e.chk_rd = 1'b0;
      for (int i = 0; i < size; i++) begin
        a = addr + 32'(i);
        ref_mem[a[7:0]] = 8'(wdata >> (8 * i));
      end
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) begin
        a = addr + 32'(i);
        v = v | (32'(ref_mem[a[7:0]]) << (8 * i));
      end
      if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      e.rd = v;
    end
  endtask

  int scnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst && bus.req_valid) begin
      if (bus.stall) begin
        chk("split_addr", bus.dm_addr, bus.req_addr + 32'(scnt));
        chk("split_we", 32'(bus.dm_we), 32'(bus.req_we));
        scnt++;
      end else begin
        if (sbq.size() == 0) begin
          chk("unexpected_response", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("stall_cycles", 32'(scnt), 32'(e.stalls));
          chk("trap", 32'(bus.misalign_trap), 32'(e.trap));
          if (e.chk_rd) chk("rdata", bus.req_rdata, e.rd);
          if (e.trap) chk("trap_we", 32'(bus.dm_we), 32'd0);
        end
        scnt = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    exp_t e;
    int k;
    model(we, f3, addr, wdata, e);
    sbq.push_back(e);
    bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    k = 0;
    while (k < 12) begin
      @(negedge clk);
      if (!bus.stall) break;
      k++;
    end
    if (k == 12) chk("stall_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic setup();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    {ref_mem[8'h13], ref_mem[8'h12], ref_mem[8'h11], ref_mem[8'h10]} = 32'h8899AABB;
    {ref_mem[8'h17], ref_mem[8'h16], ref_mem[8'h15], ref_mem[8'h14]} = 32'h11223344;
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (dm_mem[i] !== ref_mem[i]) bad++;
    chk(name, 32'(bad), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3s [8];
    f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100;
    f3s[4] = 3'b101; f3s[5] = 3'b010; f3s[6] = 3'b001; f3s[7] = 3'b011;

    // Reset with a misaligned request already presented: strobes must stay low.
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h11; bus.req_wdata = 32'h0;
    #12;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_we", 32'(bus.dm_we), 32'd0);
    chk("rst_trap", 32'(bus.misalign_trap), 32'd0);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("idle_stall", 32'(bus.stall), 32'd0);

    setup();
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    issue(1'b0, 3'b001, 32'h11, 32'h0);
    issue(1'b0, 3'b101, 32'h13, 32'h0);
    check_mem("mem_loads");

    setup();
    issue(1'b1, 3'b010, 32'h11, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    issue(1'b0, 3'b010, 32'h14, 32'h0);
    check_mem("mem_split_sw");

    setup();
    issue(1'b1, 3'b000, 32'h12, 32'h0000005A);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    issue(1'b0, 3'b010, 32'h12, 32'h0);
    check_mem("mem_sb");

    setup();
    issue(1'b0, 3'b010, 32'hFFFFFFFF, 32'h0);
    issue(1'b1, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D);
    issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    issue(1'b1, 3'b100, 32'h10, 32'h12345678);
    issue(1'b1, 3'b111, 32'h10, 32'h12345678);
    check_mem("mem_wrap_illegal");

`ifndef MISALIGN_TRAP_EN
    // Reset after the second byte of a split sw has committed: the rest must never be written.
    setup();
    mon_en = 1'b0;
    bus.req_we = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 32'h11;
    bus.req_wdata = 32'hDEADBEEF; bus.req_valid = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("mid_split_stall", 32'(bus.stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", 32'(bus.stall), 32'd0);
    chk("rst_mid_we", 32'(bus.dm_we), 32'd0);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_mem[8'h11] = 8'hEF;
    ref_mem[8'h12] = 8'hBE;
    check_mem("mem_rst_partial");
    mon_en = 1'b1;
`endif

    setup();
    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom), f3s[$urandom_range(0, 7)], 32'($urandom_range(0, 63)), $urandom);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    check_mem("mem_random");
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
